seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed four-digit seven-segment driver for a
//             common-anode display. Latches one packed BCD word per refresh
//             frame, so all four digits of a frame come from the same value.
//             Each nibble is decoded to an active-low segment pattern.
//  Ports    : clk     - system clock
//             rst_n   - asynchronous active-low reset
//             bcd_in  - packed BCD {thousands, hundreds, tens, ones}
//             dp_in   - decimal-point request per digit, active-high
//             an      - digit enables, active-low, an[0] = ones digit
//             seg     - segments {g,f,e,d,c,b,a}, active-low
//             dp      - decimal point, active-low
//  Macro    : SEG7_LEADING_ZERO_BLANK_EN - blank leading zero digits 1..3
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned    CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [3:0]       dp_shadow_q, dp_shadow_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             tick;
   logic [3:0]       nibble;
   logic [3:0]       blank;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = SEG_DASH;
      endcase
   endfunction

   assign tick   = (cnt_q == CNT_MAX);
   assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // blank[i]: every nibble from i up to 3 is zero. Chained from the top so
   // any non-zero nibble (invalid codes included) stops blanking below it.
   // Digit 0 always shows something.
   assign blank[3] = (shadow_q[15:12] == 4'd0);
   assign blank[2] = blank[3] & (shadow_q[11:8] == 4'd0);
   assign blank[1] = blank[2] & (shadow_q[7:4]  == 4'd0);
   assign blank[0] = 1'b0;
`else
   assign blank = 4'b0000;
`endif

   always_comb begin
      cnt_d       = tick ? '0 : cnt_q + 1'b1;
      idx_d       = tick ? idx_q + 2'd1 : idx_q;
      shadow_d    = shadow_q;
      dp_shadow_d = dp_shadow_q;
      // Frame boundary: last cycle of digit 3. Only here is bcd_in sampled.
      if (tick && (idx_q == 2'd3)) begin
         shadow_d    = bcd_in;
         dp_shadow_d = dp_in;
      end
      // Outputs reflect the current idx/shadow, i.e. lag idx by one clock.
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank[idx_q] ? SEG_BLANK : decode(nibble);
      dp_d  = ~dp_shadow_q[idx_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         shadow_q    <= 16'h0000;
         dp_shadow_q <= 4'b0000;
         an_q        <= 4'b1111;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         dp_shadow_q <= dp_shadow_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
//             A reference model pushes the expected {an,seg,dp} on each
//             clock; a negedge monitor pops and compares. Directed checks
//             cover reset, value display, frame coherence, invalid nibbles,
//             decimal point and reset mid-scan.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

   localparam int unsigned DIV = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_fail   = 0;

   seg7_scan_driver #(.REFRESH_DIV(DIV)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bcd_in (bcd_in),
      .dp_in  (dp_in),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Segment patterns from the display datasheet table.
   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] t [0:9];
      t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100;
      t[3] = 7'b0110000; t[4] = 7'b0011001; t[5] = 7'b0010010;
      t[6] = 7'b0000010; t[7] = 7'b1111000; t[8] = 7'b0000000;
      t[9] = 7'b0010000;
      return (v > 4'd9) ? 7'b0111111 : t[v];
   endfunction

   function automatic logic [11:0] model_out(input int i, input logic [15:0] sh,
                                             input logic [3:0] dsh);
      logic [3:0] a;
      logic [6:0] s;
      a = 4'b1111;
      a[i] = 1'b0;
      s = seg_of(4'((sh >> (4 * i)) & 16'hF));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (i >= 1 && (sh >> (4 * i)) == 16'h0) s = 7'b1111111;
`endif
      return {a, s, ~dsh[i]};
   endfunction

   // Reference model + scoreboard producer.
   logic [11:0] exp_q [$];
   int          m_cnt;
   int          m_idx;
   logic [15:0] m_sh;
   logic [3:0]  m_dsh;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0;
         m_idx <= 0;
         m_sh  <= 16'h0;
         m_dsh <= 4'h0;
         exp_q.delete();
      end else begin
         exp_q.push_back(model_out(m_idx, m_sh, m_dsh));
         if (m_cnt == DIV - 1) begin
            m_cnt <= 0;
            m_idx <= (m_idx + 1) % 4;
            if (m_idx == 3) begin
               m_sh  <= bcd_in;
               m_dsh <= dp_in;
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   // Scoreboard consumer.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("sb_in_reset", {20'h0, an, seg, dp}, {20'h0, 12'hFFF});
      end else if (exp_q.size() == 0) begin
         check("sb_pre_first_edge", {20'h0, an, seg, dp}, {20'h0, 12'hFFF});
      end else begin
         check("sb_scan", {20'h0, an, seg, dp}, {20'h0, exp_q.pop_front()});
      end
   end

   task automatic wait_an(input logic [3:0] target);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (an == target) return;
      end
      check("wait_an_timeout", {28'h0, an}, {28'h0, target});
   endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif

   initial begin
      rst_n  = 1'b0;
      bcd_in = 16'h0000;
      dp_in  = 4'b0000;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_an",  {28'h0, an},  {28'h0, 4'b1111});
      check("rst_seg", {25'h0, seg}, {25'h0, 7'b1111111});
      check("rst_dp",  {31'h0, dp},  32'h1);

      #2 rst_n = 1'b1;
      bcd_in = 16'h0255;
      @(negedge clk);
      check("first_an",  {28'h0, an},  {28'h0, 4'b1110});
      check("first_seg", {25'h0, seg}, {25'h0, 7'b1000000});

      // Value display 0255
      wait_an(4'b0111);
      wait_an(4'b1110); check("v0255_d0", {25'h0, seg}, {25'h0, 7'b0010010});
      wait_an(4'b1101); check("v0255_d1", {25'h0, seg}, {25'h0, 7'b0010010});
      wait_an(4'b1011); check("v0255_d2", {25'h0, seg}, {25'h0, 7'b0100100});
      wait_an(4'b0111); check("v0255_d3", {25'h0, seg}, {25'h0, LZ});

      // Frame coherence 0123 -> 0456 mid-frame
      wait_an(4'b1110);
      bcd_in = 16'h0123;
      wait_an(4'b0111);
      wait_an(4'b1110); check("c0123_d0", {25'h0, seg}, {25'h0, 7'b0110000});
      wait_an(4'b1101); check("c0123_d1", {25'h0, seg}, {25'h0, 7'b0100100});
      bcd_in = 16'h0456;
      wait_an(4'b1011); check("c0123_d2", {25'h0, seg}, {25'h0, 7'b1111001});
      wait_an(4'b0111); check("c0123_d3", {25'h0, seg}, {25'h0, LZ});
      wait_an(4'b1110); check("c0456_d0", {25'h0, seg}, {25'h0, 7'b0000010});
      wait_an(4'b1101); check("c0456_d1", {25'h0, seg}, {25'h0, 7'b0010010});
      wait_an(4'b1011); check("c0456_d2", {25'h0, seg}, {25'h0, 7'b0011001});
      wait_an(4'b0111); check("c0456_d3", {25'h0, seg}, {25'h0, LZ});

      // Invalid nibble and decimal point (captured at end of this frame)
      bcd_in = 16'h00A3;
      dp_in  = 4'b0100;
      wait_an(4'b1110);
      check("inv_d0",  {25'h0, seg}, {25'h0, 7'b0110000});
      check("dp_d0",   {31'h0, dp},  32'h1);
      wait_an(4'b1101);
      check("inv_d1",  {25'h0, seg}, {25'h0, 7'b0111111});
      check("dp_d1",   {31'h0, dp},  32'h1);
      wait_an(4'b1011);
      check("inv_d2",  {25'h0, seg}, {25'h0, LZ});
      check("dp_d2",   {31'h0, dp},  32'h0);
      wait_an(4'b0111);
      check("inv_d3",  {25'h0, seg}, {25'h0, LZ});
      check("dp_d3",   {31'h0, dp},  32'h1);

      // Reset mid-scan
      wait_an(4'b1011);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_an",  {28'h0, an},  {28'h0, 4'b1111});
      check("mid_rst_seg", {25'h0, seg}, {25'h0, 7'b1111111});
      check("mid_rst_dp",  {31'h0, dp},  32'h1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("restart_an",  {28'h0, an},  {28'h0, 4'b1110});
      check("restart_seg", {25'h0, seg}, {25'h0, 7'b1000000});
      check("restart_dp",  {31'h0, dp},  32'h1);

      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
